exec_mem_stage: RTL and testbench

Execute/memory slice of the 8-bit single-cycle core.
- Holds the program-counter register.
- Performs the ALU operation on the two register-file read operands.
- Hosts the 256-byte data memory, addressed by the ALU result.
- Upstream logic supplies the next PC, operands, ALU control and write enable. Downstream muxes consume the PC, ALU result, flags and memory read data.

---
 rtl/exec_mem_pkg.sv | 20 ++
 rtl/exec_mem_if.sv | 25 ++
 rtl/alu_core.sv | 53 +++++
 rtl/exec_mem_stage.sv | 55 +++++
 tb/tb_exec_mem_stage.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/exec_mem_pkg.sv
// Shared widths, ALU opcode encoding and flag bit positions for the execute/memory slice.
package exec_mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    // Positions within the 4-bit {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_mem_if.sv
// Bundle between the decode/register-file side (master) and the execute/memory stage (slave).
interface exec_mem_if;
    import exec_mem_pkg::*;

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    alu_op_e           alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output pc_next, src_a, src_b, alu_ctrl, mem_write,
        input  pc, alu_result, alu_flags, mem_rdata
    );

    modport slave (
        input  pc_next, src_a, src_b, alu_ctrl, mem_write,
        output pc, alu_result, alu_flags, mem_rdata
    );

endinterface

// File: rtl/alu_core.sv
// Combinational 2-bit-opcode ALU with {N,Z,C,V} flags; zero latency, no flow control.
module alu_core
    import exec_mem_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] res;
    logic              carry;
    logic              ovf;

    always_comb begin
        sum_ext = '0;
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        unique case (op_i)
            ALU_ADD: begin
                sum_ext = {1'b0, a_i} + {1'b0, b_i};
                res     = sum_ext[MSB:0];
                carry   = sum_ext[DATA_W];
                ovf     = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                // Two's-complement subtract: carry out set means no borrow (A >= B)
                sum_ext = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
                res     = sum_ext[MSB:0];
                carry   = sum_ext[DATA_W];
                ovf     = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            ALU_AND: res = a_i & b_i;
            ALU_OR:  res = a_i | b_i;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_N] = res[MSB];
        flags_o[FLAG_Z] = (res == '0);
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_V] = ovf;
    end

    assign result_o = res;

endmodule

// File: rtl/exec_mem_stage.sv
// Execute/memory slice: PC register, ALU, and 256-entry data memory with async read.
// PC and memory write take effect at the clock edge; sync reset clears both and drops any write.
module exec_mem_stage
    import exec_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    exec_mem_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        pc_d = bus.pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    alu_core u_alu (
        .a_i      (bus.src_a),
        .b_i      (bus.src_b),
        .op_i     (bus.alu_ctrl),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    // Reset wins over a coincident write so a reset edge always leaves memory all-zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.mem_write) begin
            mem_q[alu_res] <= bus.src_b;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.alu_result = alu_res;
    assign bus.alu_flags  = alu_flags;
    assign bus.mem_rdata  = mem_q[alu_res];

endmodule

// File: tb/tb_exec_mem_stage.sv
// Directed bench for exec_mem_stage: stimulus queues expected values, a negedge monitor checks them.
module tb_exec_mem_stage;
    import exec_mem_pkg::*;

    logic clk;
    logic rst;

    exec_mem_if bus ();

    exec_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One queue entry per comparison: 0 = pc, 1 = alu_result, 2 = alu_flags, 3 = mem_rdata
    int         kind_q[$];
    logic [7:0] exp_q[$];
    string      name_q[$];

    int checks = 0;
    int errors = 0;

    task automatic expect_val(input int kind, input logic [7:0] val, input string name);
        kind_q.push_back(kind);
        exp_q.push_back(val);
        name_q.push_back(name);
    endtask

    // Advance to just after the next rising edge; inputs change here, monitor samples at negedge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input logic [7:0] a, input logic [7:0] b, input alu_op_e op,
                           input logic [7:0] res, input logic [3:0] flg, input string name);
        step();
        bus.src_a    = a;
        bus.src_b    = b;
        bus.alu_ctrl = op;
        expect_val(1, res, {name, "_res"});
        expect_val(2, {4'b0, flg}, {name, "_flags"});
    endtask

    always @(negedge clk) begin
        while (kind_q.size() > 0) begin
            int         k;
            logic [7:0] e;
            logic [7:0] act;
            string      n;
            k   = kind_q.pop_front();
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            case (k)
                0:       act = bus.pc;
                1:       act = bus.alu_result;
                2:       act = {4'b0, bus.alu_flags};
                default: act = bus.mem_rdata;
            endcase
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got 0x%02h expected 0x%02h", n, act, e);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.pc_next   = 8'h55;
        bus.src_a     = 8'h00;
        bus.src_b     = 8'h00;
        bus.alu_ctrl  = ALU_ADD;
        bus.mem_write = 1'b0;

        // Reset and PC sequencing
        step();
        expect_val(0, 8'h00, "rst_pc");
        expect_val(3, 8'h00, "rst_mem");
        rst         = 1'b0;
        bus.pc_next = 8'h01;
        step();
        expect_val(0, 8'h01, "pc_01");
        bus.pc_next = 8'h02;
        step();
        expect_val(0, 8'h02, "pc_02");
        bus.pc_next = 8'hFF;
        step();
        expect_val(0, 8'hFF, "pc_ff");
        bus.pc_next = 8'h00;
        step();
        expect_val(0, 8'h00, "pc_wrap");

        // ALU vectors, flags as {N,Z,C,V}
        alu_vec(8'h7F, 8'h01, ALU_ADD, 8'h80, 4'b1001, "add_ovf");
        alu_vec(8'hFF, 8'h01, ALU_ADD, 8'h00, 4'b0110, "add_carry");
        alu_vec(8'h05, 8'h05, ALU_SUB, 8'h00, 4'b0110, "sub_eq");
        alu_vec(8'h03, 8'h05, ALU_SUB, 8'hFE, 4'b1000, "sub_borrow");
        alu_vec(8'h80, 8'h01, ALU_SUB, 8'h7F, 4'b0011, "sub_ovf");
        alu_vec(8'h00, 8'h01, ALU_SUB, 8'hFF, 4'b1000, "sub_neg1");
        alu_vec(8'hF0, 8'h3C, ALU_AND, 8'h30, 4'b0000, "and");
        alu_vec(8'hF0, 8'h3C, ALU_OR,  8'hFC, 4'b1000, "or");
        alu_vec(8'h0F, 8'hF0, ALU_AND, 8'h00, 4'b0100, "and_zero");

        // Memory write at 0x10 + 0x20 = 0x30
        alu_vec(8'h10, 8'h20, ALU_ADD, 8'h30, 4'b0000, "mem_addr");
        bus.mem_write = 1'b1;
        expect_val(3, 8'h00, "mem_old");
        step();
        bus.mem_write = 1'b0;
        expect_val(3, 8'h20, "mem_new");
        step();
        bus.src_a    = 8'h30;
        bus.src_b    = 8'h00;
        bus.alu_ctrl = ALU_OR;
        expect_val(3, 8'h20, "mem_nowr_pre");
        step();
        expect_val(3, 8'h20, "mem_nowr_post");
        step();
        bus.src_a = 8'h31;
        expect_val(3, 8'h00, "mem_neighbour");

        // Write 0xAA at 0x86 + 0xAA = 0x30, and move the PC off zero
        step();
        bus.src_a     = 8'h86;
        bus.src_b     = 8'hAA;
        bus.alu_ctrl  = ALU_ADD;
        bus.mem_write = 1'b1;
        bus.pc_next   = 8'h42;
        expect_val(1, 8'h30, "aa_addr");
        step();
        bus.mem_write = 1'b0;
        expect_val(3, 8'hAA, "mem_aa");
        expect_val(0, 8'h42, "pc_42");

        // Reset coincident with a write of 0x55 to 0x30 (0xDB + 0x55)
        step();
        bus.src_a     = 8'hDB;
        bus.src_b     = 8'h55;
        bus.mem_write = 1'b1;
        rst           = 1'b1;
        expect_val(1, 8'h30, "prio_addr");
        expect_val(3, 8'hAA, "prio_pre");
        step();
        rst           = 1'b0;
        bus.mem_write = 1'b0;
        expect_val(0, 8'h00, "prio_pc");
        expect_val(3, 8'h00, "prio_mem");
        step();
        bus.src_a    = 8'h30;
        bus.src_b    = 8'h00;
        bus.alu_ctrl = ALU_OR;
        expect_val(3, 8'h00, "prio_mem_or");
        expect_val(0, 8'h42, "pc_after_rst");

        repeat (3) @(negedge clk);
        #1;
        if (kind_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", kind_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
